// File: rtl/sram_responder.sv
// Fixed-latency SRAM-like responder: one outstanding request, single-cycle data_ok pulse.
// Define SRAM_RESP_BYTE_STROBE_EN to make we a 4-bit byte-strobe vector.
module sram_responder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
`ifdef SRAM_RESP_BYTE_STROBE_EN
   input  logic [3:0]  we,
`else
   input  logic        we,
`endif
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned Depth   = 2 ** ADDR_W;
   localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   function automatic logic in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ((off >> (ADDR_W + 2)) == '0);
   endfunction

   function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return ADDR_W'(off >> 2);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return res;
   endfunction

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [31:0]         addr_q, wdata_q;
   logic [3:0]          strb_q;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                latch;
   logic [3:0]          strb_in;
   logic [31:0]         mem [Depth];

`ifdef SRAM_RESP_BYTE_STROBE_EN
   assign strb_in = we;
`else
   assign strb_in = {4{we}};
`endif

   // Request being completed next: latched while waiting, live inputs when LATENCY==1.
   logic [31:0]         src_addr;
   logic [3:0]          src_strb;
   logic [ADDR_W-1:0]   src_idx, cur_idx;
   logic                src_in, cur_in;
   logic                commit;
   logic [31:0]         commit_data;

   assign src_addr    = (state_q == StWait) ? addr_q : addr;
   assign src_strb    = (state_q == StWait) ? strb_q : strb_in;
   assign src_idx     = word_index(src_addr);
   assign src_in      = in_range(src_addr);
   assign cur_idx     = word_index(addr_q);
   assign cur_in      = in_range(addr_q);
   assign commit      = (state_q == StResp) && (strb_q != 4'd0) && cur_in;
   assign commit_data = merge(mem[cur_idx], wdata_q, strb_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      unique case (state_q)
         StIdle, StResp: begin
            if (req) begin
               latch   = 1'b1;
               cnt_d   = LoadCnt;
               state_d = (LATENCY == 1) ? StResp : StWait;
            end else if (state_q == StResp) begin
               state_d = StIdle;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StResp;
         end
         default: state_d = StIdle;
      endcase
   end

   // Back-to-back read of the word written in this RESP cycle sees the merged data.
   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (state_d == StResp) begin
         if (!src_in) begin
            rdata_d = '0;
            err_d   = 1'b1;
         end else if (src_strb != 4'd0) begin
            rdata_d = '0;
         end else if (commit && (src_idx == cur_idx)) begin
            rdata_d = commit_data;
         end else begin
            rdata_d = mem[src_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (latch) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            strb_q  <= strb_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit) mem[cur_idx] <= commit_data;
   end

   assign addr_ok = (state_q != StWait);
   assign data_ok = (state_q == StResp);
   assign rdata   = rdata_q;
   assign err     = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances with LATENCY 1, 2 and 3 against an array model.
module tb_sram_responder;

   localparam logic [31:0] Base = 32'h1c000000;

`ifdef SRAM_RESP_BYTE_STROBE_EN
   typedef logic [3:0] we_t;
`else
   typedef logic we_t;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_s     [3];
   we_t         we_s      [3];
   logic [31:0] addr_s    [3];
   logic [31:0] wdata_s   [3];
   logic        addr_ok_s [3];
   logic        data_ok_s [3];
   logic [31:0] rdata_s   [3];
   logic        err_s     [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sram_responder #(
         .ADDR_W    (10),
         .LATENCY   (g + 1),
         .BASE_ADDR (32'h1c000000)
      ) u_dut (
         .clk     (clk),
         .resetn  (resetn),
         .req     (req_s[g]),
         .we      (we_s[g]),
         .addr    (addr_s[g]),
         .wdata   (wdata_s[g]),
         .addr_ok (addr_ok_s[g]),
         .data_ok (data_ok_s[g]),
         .rdata   (rdata_s[g]),
         .err     (err_s[g])
      );
   end

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mm   [3][1024];
   logic        merr [3];

   typedef struct {
      logic [3:0]  s;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   function automatic we_t to_we(input logic [3:0] s);
`ifdef SRAM_RESP_BYTE_STROBE_EN
      return s;
`else
      return |s;
`endif
   endfunction

   function automatic logic [3:0] eff_strb(input logic [3:0] s);
`ifdef SRAM_RESP_BYTE_STROBE_EN
      return s;
`else
      return {4{|s}};
`endif
   endfunction

   function automatic logic in_rng(input logic [31:0] a);
      return (a >= Base) && ((a - Base) < 32'd4096);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - Base) >> 2);
   endfunction

   // Transaction-level model: what a completed request returns and does to memory.
   task automatic model_apply(input int n, input logic [3:0] s, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] exp_rd);
      logic [3:0] es;
      es     = eff_strb(s);
      exp_rd = 32'd0;
      if (!in_rng(a)) begin
         merr[n] = 1'b1;
      end else if (es != 4'd0) begin
         for (int i = 0; i < 4; i++) begin
            if (es[i]) mm[n][widx(a)][8*i +: 8] = d[8*i +: 8];
         end
      end else begin
         exp_rd = mm[n][widx(a)];
      end
   endtask

   task automatic txn(input int n, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic e,
                      output logic dok2, output int lat);
      int k;
      @(negedge clk);
      req_s[n]   = 1'b1;
      we_s[n]    = to_we(s);
      addr_s[n]  = a;
      wdata_s[n] = d;
      k = 0;
      while (!addr_ok_s[n] && k < 32) begin
         @(negedge clk);
         k++;
      end
      if (!addr_ok_s[n]) begin
         failures++;
         $display("FAIL accept_timeout dut%0d addr=%h", n, a);
      end
      @(negedge clk);
      // Inputs change freely once accepted; the DUT must use its latched copy.
      req_s[n]   = 1'b0;
      addr_s[n]  = $urandom;
      wdata_s[n] = $urandom;
      we_s[n]    = to_we(4'($urandom));
      lat = 1;
      while (!data_ok_s[n] && lat < 32) begin
         @(negedge clk);
         lat++;
      end
      rd = rdata_s[n];
      @(negedge clk);
      e    = err_s[n];
      dok2 = data_ok_s[n];
   endtask

   task automatic run_check(input int n, input logic [3:0] s, input logic [31:0] a,
                            input logic [31:0] d);
      logic [31:0] exp_rd, rd;
      logic        e, dok2;
      int          lat;
      model_apply(n, s, a, d, exp_rd);
      txn(n, s, a, d, rd, e, dok2, lat);
      chk($sformatf("latency dut%0d a=%h", n, a), 32'(lat), 32'(n + 1));
      chk($sformatf("rdata dut%0d a=%h s=%h", n, a, s), rd, exp_rd);
      chk1($sformatf("err dut%0d a=%h", n, a), e, merr[n]);
      chk1($sformatf("pulse_width dut%0d", n), dok2, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, dummy;
      logic        e, dok2;
      int          lat, idx, r;
      logic [31:0] a;
      logic [3:0]  s;

      resetn = 1'b0;
      for (int n = 0; n < 3; n++) begin
         req_s[n] = 1'b0; we_s[n] = to_we(4'd0); addr_s[n] = Base; wdata_s[n] = '0;
         merr[n] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int n = 0; n < 3; n++) begin
         chk1($sformatf("reset_addr_ok dut%0d", n), addr_ok_s[n], 1'b1);
         chk1($sformatf("reset_data_ok dut%0d", n), data_ok_s[n], 1'b0);
         chk($sformatf("reset_rdata dut%0d", n), rdata_s[n], 32'd0);
         chk1($sformatf("reset_err dut%0d", n), err_s[n], 1'b0);
      end
      resetn = 1'b1;

      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 17; i++) begin
            idx = (i == 16) ? 1023 : i;
            run_check(n, 4'hf, Base + 32'(4 * idx), $urandom);
         end
      end

      // Directed vectors on the LATENCY=2 instance.
      tbl[0] = '{4'hf, 32'h1c000010, 32'hdeadbeef, 32'h0,        1'b0};
      tbl[1] = '{4'h0, 32'h1c000010, 32'h0,        32'hdeadbeef, 1'b0};
      tbl[2] = '{4'hf, 32'h1c000000, 32'hcafef00d, 32'h0,        1'b0};
      tbl[3] = '{4'h0, 32'h1bfffffc, 32'h0,        32'h0,        1'b1};
      tbl[4] = '{4'hf, 32'h1c001000, 32'h00000099, 32'h0,        1'b1};
      tbl[5] = '{4'h0, 32'h1c000000, 32'h0,        32'hcafef00d, 1'b1};
      tbl[6] = '{4'hf, 32'h1c000ffc, 32'h0badcafe, 32'h0,        1'b1};
      tbl[7] = '{4'h0, 32'h1c000ffe, 32'h0,        32'h0badcafe, 1'b1};
      for (int i = 0; i < 8; i++) begin
         txn(1, tbl[i].s, tbl[i].a, tbl[i].d, rd, e, dok2, lat);
         model_apply(1, tbl[i].s, tbl[i].a, tbl[i].d, dummy);
         chk($sformatf("tbl%0d latency", i), 32'(lat), 32'd2);
         chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
         chk1($sformatf("tbl%0d err", i), e, tbl[i].exp_err);
      end

      // LATENCY=1 streaming reads with req held high.
      for (int i = 0; i < 3; i++) run_check(0, 4'hf, Base + 32'(4 * i), 32'(i + 1));
      @(negedge clk);
      req_s[0] = 1'b1; we_s[0] = to_we(4'd0); addr_s[0] = Base;
      chk1("stream_addr_ok0", addr_ok_s[0], 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1($sformatf("stream_data_ok%0d", i), data_ok_s[0], 1'b1);
         chk($sformatf("stream_rdata%0d", i), rdata_s[0], 32'(i + 1));
         chk1($sformatf("stream_addr_ok%0d", i + 1), addr_ok_s[0], 1'b1);
         if (i < 2) addr_s[0] = Base + 32'(4 * (i + 1));
         else req_s[0] = 1'b0;
      end
      @(negedge clk);
      chk1("stream_end_data_ok", data_ok_s[0], 1'b0);

      // LATENCY=1 write then back-to-back read of the same word.
      @(negedge clk);
      req_s[0] = 1'b1; we_s[0] = to_we(4'hf); addr_s[0] = Base + 32'd8; wdata_s[0] = 32'h55aa55aa;
      @(negedge clk);
      chk1("fwd_wr_data_ok", data_ok_s[0], 1'b1);
      chk("fwd_wr_rdata", rdata_s[0], 32'd0);
      we_s[0] = to_we(4'd0);
      @(negedge clk);
      chk1("fwd_rd_data_ok", data_ok_s[0], 1'b1);
      chk("fwd_rd_rdata", rdata_s[0], 32'h55aa55aa);
      req_s[0] = 1'b0;
      model_apply(0, 4'hf, Base + 32'd8, 32'h55aa55aa, dummy);

      // LATENCY=3: second request held from the cycle after the first is accepted.
      run_check(2, 4'hf, Base + 32'd4, 32'h000000a1);
      run_check(2, 4'hf, Base + 32'd8, 32'h000000b2);
      @(negedge clk);
      req_s[2] = 1'b1; we_s[2] = to_we(4'd0); addr_s[2] = Base + 32'd4;
      chk1("b2b_addr_ok0", addr_ok_s[2], 1'b1);
      @(negedge clk);
      addr_s[2] = Base + 32'd8;
      chk1("b2b_addr_ok1", addr_ok_s[2], 1'b0);
      chk1("b2b_data_ok1", data_ok_s[2], 1'b0);
      @(negedge clk);
      chk1("b2b_addr_ok2", addr_ok_s[2], 1'b0);
      @(negedge clk);
      chk1("b2b_data_ok3", data_ok_s[2], 1'b1);
      chk("b2b_rdata3", rdata_s[2], 32'h000000a1);
      chk1("b2b_addr_ok3", addr_ok_s[2], 1'b1);
      @(negedge clk);
      req_s[2] = 1'b0;
      chk1("b2b_data_ok4", data_ok_s[2], 1'b0);
      chk1("b2b_addr_ok4", addr_ok_s[2], 1'b0);
      @(negedge clk);
      chk1("b2b_addr_ok5", addr_ok_s[2], 1'b0);
      @(negedge clk);
      chk1("b2b_data_ok6", data_ok_s[2], 1'b1);
      chk("b2b_rdata6", rdata_s[2], 32'h000000b2);
      @(negedge clk);
      chk1("b2b_data_ok7", data_ok_s[2], 1'b0);
      chk1("b2b_addr_ok7", addr_ok_s[2], 1'b1);

      // Reset while a write is waiting: it must never complete or reach memory.
      run_check(1, 4'hf, Base + 32'h20, 32'h0f0f0f0f);
      @(negedge clk);
      req_s[1] = 1'b1; we_s[1] = to_we(4'hf); addr_s[1] = Base + 32'h20; wdata_s[1] = 32'h12345678;
      chk1("abort_accept", addr_ok_s[1], 1'b1);
      @(negedge clk);
      req_s[1] = 1'b0;
      chk1("abort_in_wait", addr_ok_s[1], 1'b0);
      resetn = 1'b0;
      #1;
      chk1("abort_reset_addr_ok", addr_ok_s[1], 1'b1);
      chk1("abort_reset_data_ok", data_ok_s[1], 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      for (int n = 0; n < 3; n++) merr[n] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk1($sformatf("abort_no_data_ok%0d", i), data_ok_s[1], 1'b0);
      end
      for (int n = 0; n < 3; n++) chk1($sformatf("abort_err_clear dut%0d", n), err_s[n], 1'b0);
      run_check(1, 4'h0, Base + 32'h20, 32'h0);

`ifdef SRAM_RESP_BYTE_STROBE_EN
      run_check(1, 4'hf, Base + 32'h40, 32'h11223344);
      run_check(1, 4'b0101, Base + 32'h40, 32'haabbccdd);
      txn(1, 4'h0, Base + 32'h40, 32'h0, rd, e, dok2, lat);
      chk("strobe_merge", rd, 32'h11bb33dd);
      model_apply(1, 4'h0, Base + 32'h40, 32'h0, dummy);
`endif

      // Randomized traffic, including out-of-range and unaligned addresses.
      for (int n = 0; n < 3; n++) begin
         for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 6) a = Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else if (r == 7) a = Base + 32'd4092;
            else if (r == 8) a = Base - 32'(4 * $urandom_range(1, 4));
            else a = Base + 32'd4096 + 32'(4 * $urandom_range(0, 3));
`ifdef SRAM_RESP_BYTE_STROBE_EN
            s = 4'($urandom_range(0, 15));
`else
            s = ($urandom_range(0, 1) == 1) ? 4'hf : 4'h0;
`endif
            run_check(n, s, a, $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
